// File: rtl/collision_hit_detector.sv
// Player/object collision detector with per-frame report handshake.
// Optional macro COLLISION_HIT_COUNT_EN adds a saturating hit-cycle count.
module collision_hit_detector #(
    parameter int NUM_BRICKS = 8
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic                  playerDrawingRequest,
    input  logic [3:0]            playerHitEdgeCode,
    input  logic [NUM_BRICKS-1:0] brickDrawingRequest,
    input  logic                  borderDrawingRequest,
    input  logic                  reportAck,
    output logic                  collisionPulse,
    output logic                  reportValid,
    output logic [3:0]            reportEdges,
    output logic [NUM_BRICKS-1:0] reportBricks,
    output logic                  reportBorder,
`ifdef COLLISION_HIT_COUNT_EN
    output logic [7:0]            reportHitCount,
`endif
    output logic                  reportOverrun
);

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } state_t;

    state_t                r_state;
    logic [3:0]            r_edgeAcc;
    logic [NUM_BRICKS-1:0] r_brickAcc;
    logic                  r_borderAcc;
    logic                  r_anyHit;

    logic                  w_hit;
    logic                  w_load;
    logic [3:0]            w_edgeTerm;
    logic [NUM_BRICKS-1:0] w_brickTerm;
    logic                  w_borderTerm;

    assign w_hit = playerDrawingRequest &
                   ((|brickDrawingRequest) | borderDrawingRequest);
    assign w_edgeTerm   = w_hit ? playerHitEdgeCode : 4'h0;
    assign w_brickTerm  = brickDrawingRequest & {NUM_BRICKS{playerDrawingRequest}};
    assign w_borderTerm = borderDrawingRequest & playerDrawingRequest;
    assign w_load       = startOfFrame & r_anyHit;

    // The startOfFrame pixel's hit terms seed the new frame's accumulators.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            r_edgeAcc   <= '0;
            r_brickAcc  <= '0;
            r_borderAcc <= 1'b0;
            r_anyHit    <= 1'b0;
        end else if (startOfFrame) begin
            r_edgeAcc   <= w_edgeTerm;
            r_brickAcc  <= w_brickTerm;
            r_borderAcc <= w_borderTerm;
            r_anyHit    <= w_hit;
        end else begin
            r_edgeAcc   <= r_edgeAcc | w_edgeTerm;
            r_brickAcc  <= r_brickAcc | w_brickTerm;
            r_borderAcc <= r_borderAcc | w_borderTerm;
            r_anyHit    <= r_anyHit | w_hit;
        end
    end

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            collisionPulse <= 1'b0;
        end else begin
            collisionPulse <= w_hit & (startOfFrame | ~r_anyHit);
        end
    end

`ifdef COLLISION_HIT_COUNT_EN
    logic [7:0] r_hitCnt;
    logic [7:0] w_cntNext;

    assign w_cntNext = (r_hitCnt == 8'hFF) ? 8'hFF : r_hitCnt + 8'd1;

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            r_hitCnt       <= '0;
            reportHitCount <= '0;
        end else begin
            if (startOfFrame) begin
                r_hitCnt <= {7'd0, w_hit};
            end else if (w_hit) begin
                r_hitCnt <= w_cntNext;
            end
            if (w_load) begin
                reportHitCount <= r_hitCnt;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            r_state       <= S_EMPTY;
            reportValid   <= 1'b0;
            reportEdges   <= '0;
            reportBricks  <= '0;
            reportBorder  <= 1'b0;
            reportOverrun <= 1'b0;
        end else begin
            if (w_load) begin
                reportEdges  <= r_edgeAcc;
                reportBricks <= r_brickAcc;
                reportBorder <= r_borderAcc;
            end
            unique case (r_state)
                S_EMPTY: begin
                    if (w_load) begin
                        r_state     <= S_FULL;
                        reportValid <= 1'b1;
                    end
                end
                S_FULL: begin
                    // A reload wins over a same-cycle ack; the ack only
                    // suppresses the overrun flag.
                    if (w_load) begin
                        if (!reportAck) begin
                            reportOverrun <= 1'b1;
                        end
                    end else if (reportAck) begin
                        r_state     <= S_EMPTY;
                        reportValid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    reportValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_hit_detector.sv
// Directed self-checking bench for collision_hit_detector with a
// queue of expected frame reports.
module tb_collision_hit_detector;

    localparam int NB = 8;

    typedef struct {
        logic [3:0]    edges;
        logic [NB-1:0] bricks;
        logic          border;
        logic          overrun;
        logic [7:0]    cnt;
    } rep_t;

    logic          clk = 1'b0;
    logic          resetN;
    logic          startOfFrame;
    logic          playerDrawingRequest;
    logic [3:0]    playerHitEdgeCode;
    logic [NB-1:0] brickDrawingRequest;
    logic          borderDrawingRequest;
    logic          reportAck;
    logic          collisionPulse;
    logic          reportValid;
    logic [3:0]    reportEdges;
    logic [NB-1:0] reportBricks;
    logic          reportBorder;
    logic          reportOverrun;
`ifdef COLLISION_HIT_COUNT_EN
    logic [7:0]    reportHitCount;
`endif

    int   n_assert = 0;
    int   n_fail   = 0;
    rep_t q[$];

    collision_hit_detector #(.NUM_BRICKS(NB)) dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .playerDrawingRequest (playerDrawingRequest),
        .playerHitEdgeCode    (playerHitEdgeCode),
        .brickDrawingRequest  (brickDrawingRequest),
        .borderDrawingRequest (borderDrawingRequest),
        .reportAck            (reportAck),
        .collisionPulse       (collisionPulse),
        .reportValid          (reportValid),
        .reportEdges          (reportEdges),
        .reportBricks         (reportBricks),
        .reportBorder         (reportBorder),
`ifdef COLLISION_HIT_COUNT_EN
        .reportHitCount       (reportHitCount),
`endif
        .reportOverrun        (reportOverrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel, clock it, then check the pulse it should cause.
    task automatic px(input logic pdr, input logic [3:0] e,
                      input logic [NB-1:0] b, input logic bd,
                      input logic sof, input logic ack, input logic ep);
        playerDrawingRequest = pdr;
        playerHitEdgeCode    = e;
        brickDrawingRequest  = b;
        borderDrawingRequest = bd;
        startOfFrame         = sof;
        reportAck            = ack;
        @(posedge clk);
        #1;
        chk("pulse", {31'd0, collisionPulse}, {31'd0, ep});
    endtask

    task automatic rep_check(input string tag);
        rep_t r;
        if (q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            r = q.pop_front();
            chk({tag, "_valid"}, {31'd0, reportValid}, 32'd1);
            chk({tag, "_edges"}, {28'd0, reportEdges}, {28'd0, r.edges});
            chk({tag, "_bricks"}, {24'd0, reportBricks}, {24'd0, r.bricks});
            chk({tag, "_border"}, {31'd0, reportBorder}, {31'd0, r.border});
            chk({tag, "_ovr"}, {31'd0, reportOverrun}, {31'd0, r.overrun});
`ifdef COLLISION_HIT_COUNT_EN
            chk({tag, "_cnt"}, {24'd0, reportHitCount}, {24'd0, r.cnt});
`endif
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_pulse"}, {31'd0, collisionPulse}, 32'd0);
        chk({tag, "_valid"}, {31'd0, reportValid}, 32'd0);
        chk({tag, "_edges"}, {28'd0, reportEdges}, 32'd0);
        chk({tag, "_bricks"}, {24'd0, reportBricks}, 32'd0);
        chk({tag, "_border"}, {31'd0, reportBorder}, 32'd0);
        chk({tag, "_ovr"}, {31'd0, reportOverrun}, 32'd0);
`ifdef COLLISION_HIT_COUNT_EN
        chk({tag, "_cnt"}, {24'd0, reportHitCount}, 32'd0);
`endif
    endtask

    initial begin
        resetN = 1'b1;
        startOfFrame = 1'b0;
        playerDrawingRequest = 1'b0;
        playerHitEdgeCode = 4'h0;
        brickDrawingRequest = '0;
        borderDrawingRequest = 1'b0;
        reportAck = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        all_zero("reset");
        resetN = 1'b0;

        // First frame has no hits: no report
        px(0, 4'h0, 8'h00, 0, 1, 0, 0);
        chk("empty_valid", {31'd0, reportValid}, 32'd0);

        // Single hit
        px(0, 4'h0, 8'h00, 0, 0, 0, 0);
        px(1, 4'h8, 8'h04, 0, 0, 0, 1);
        px(0, 4'h0, 8'h00, 0, 0, 0, 0);
        q.push_back('{4'h8, 8'h04, 1'b0, 1'b0, 8'd1});
        px(0, 4'h0, 8'h00, 0, 1, 0, 0);
        rep_check("single");
        px(0, 4'h0, 8'h00, 0, 0, 1, 0);
        chk("single_ack", {31'd0, reportValid}, 32'd0);

        // Multi-hit frame, border on third hit
        px(1, 4'h8, 8'h01, 0, 0, 0, 1);
        px(1, 4'h1, 8'h02, 0, 0, 0, 0);
        px(1, 4'h0, 8'h00, 1, 0, 0, 0);
        q.push_back('{4'h9, 8'h03, 1'b1, 1'b0, 8'd3});
        px(0, 4'h0, 8'h00, 0, 1, 0, 0);
        rep_check("multi");
        px(0, 4'h0, 8'h00, 0, 0, 1, 0);
        chk("multi_ack", {31'd0, reportValid}, 32'd0);

        // No overlap: no pulse, no report, old data kept
        px(1, 4'hF, 8'h00, 0, 0, 0, 0);
        px(0, 4'h0, 8'hFF, 0, 0, 0, 0);
        px(0, 4'h0, 8'h00, 1, 0, 0, 0);
        px(0, 4'h0, 8'h00, 0, 1, 0, 0);
        chk("nohit_valid", {31'd0, reportValid}, 32'd0);
        chk("nohit_edges", {28'd0, reportEdges}, 32'h9);
        chk("nohit_bricks", {24'd0, reportBricks}, 32'h03);

        // Ack in the same cycle as a reload: no overrun
        px(1, 4'h2, 8'h10, 0, 0, 0, 1);
        q.push_back('{4'h2, 8'h10, 1'b0, 1'b0, 8'd1});
        px(0, 4'h0, 8'h00, 0, 1, 0, 0);
        rep_check("frameA");
        px(1, 4'h4, 8'h20, 1, 0, 0, 1);
        q.push_back('{4'h4, 8'h20, 1'b1, 1'b0, 8'd1});
        px(0, 4'h0, 8'h00, 0, 1, 1, 0);
        rep_check("frameB");
        // Reload without ack: overrun
        px(1, 4'h1, 8'h00, 1, 0, 0, 1);
        q.push_back('{4'h1, 8'h00, 1'b1, 1'b1, 8'd1});
        px(0, 4'h0, 8'h00, 0, 1, 0, 0);
        rep_check("frameC");
        px(0, 4'h0, 8'h00, 0, 0, 1, 0);
        chk("ovr_ack_valid", {31'd0, reportValid}, 32'd0);
        chk("ovr_sticky", {31'd0, reportOverrun}, 32'd1);

        // Hit on the startOfFrame pixel belongs to the new frame
        px(1, 4'h4, 8'h80, 0, 1, 0, 1);
        chk("sofhit_noreport", {31'd0, reportValid}, 32'd0);
        px(1, 4'h8, 8'h00, 1, 0, 0, 0);
        q.push_back('{4'hC, 8'h80, 1'b1, 1'b1, 8'd2});
        px(1, 4'h2, 8'h01, 0, 1, 0, 1);
        rep_check("sofhit");
        px(0, 4'h0, 8'h00, 0, 0, 1, 0);
        chk("sofhit_ack", {31'd0, reportValid}, 32'd0);

        // 301 hit cycles in one frame: count saturates
        for (int i = 0; i < 300; i++) begin
            px(1, 4'h1, 8'h02, 0, 0, 0, 0);
        end
        q.push_back('{4'h3, 8'h03, 1'b0, 1'b1, 8'd255});
        px(0, 4'h0, 8'h00, 0, 1, 0, 0);
        rep_check("sat");
        px(0, 4'h0, 8'h00, 0, 0, 1, 0);

        // Asynchronous reset mid-frame after hits
        px(1, 4'h8, 8'h04, 0, 0, 0, 1);
        px(1, 4'h1, 8'h00, 1, 0, 0, 0);
        playerDrawingRequest = 1'b0;
        borderDrawingRequest = 1'b0;
        #2;
        resetN = 1'b1;
        #1;
        all_zero("midrst");
        #3;
        resetN = 1'b0;
        px(0, 4'h0, 8'h00, 0, 1, 0, 0);
        chk("rst_noreport", {31'd0, reportValid}, 32'd0);
        chk("rst_ovr", {31'd0, reportOverrun}, 32'd0);
        chk("queue_empty", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
